// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU codes, select enums and the decoded bundle.
// Optional illegal-instruction field is present only when DECODE_ILLEGAL_CHECK_EN is defined.
package decode_pkg;

  localparam int DEC_XLEN   = 32;
  localparam int DEC_REG_AW = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Other ALU ops are passed through directly as {bit30,funct3}.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'b00,
    SRC_A_PC   = 2'b01,
    SRC_A_ZERO = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef struct packed {
    logic [DEC_XLEN-1:0]   pc;
    logic [DEC_REG_AW-1:0] rs1;
    logic [DEC_REG_AW-1:0] rs2;
    logic [DEC_REG_AW-1:0] rd;
    logic [DEC_XLEN-1:0]   imm;
    logic [3:0]            alu_ctrl;
    src_a_e                src_a;
    logic                  src_imm;
    logic                  branch;
    logic                  jump;
    logic                  jalr;
    logic [2:0]            br_funct3;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [2:0]            mem_size;
    wb_sel_e               wb_sel;
    logic                  reg_wr;
`ifdef DECODE_ILLEGAL_CHECK_EN
    logic                  illegal;
`endif
  } decoded_t;

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I decoder: instruction word (plus PC pass-through) to decoded_t.
// Illegal-encoding checks are built only when DECODE_ILLEGAL_CHECK_EN is defined.
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0]         instr,
  input  logic [DEC_XLEN-1:0] pc,
  output decoded_t            dec
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [DEC_XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  assign imm_i = {{(DEC_XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(DEC_XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(DEC_XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{(DEC_XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic illegal;

  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OP_R:      illegal = !((f7 == 7'b0000000) ||
                             (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      OP_I: begin
        if (f3 == 3'b001)
          illegal = (f7 != 7'b0000000);
        else if (f3 == 3'b101)
          illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      OP_BRANCH: illegal = (f3 == 3'b010) || (f3 == 3'b011);
      OP_LOAD:   illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      OP_STORE:  illegal = (f3 > 3'b010);
      OP_JALR:   illegal = (f3 != 3'b000);
      OP_LUI, OP_AUIPC, OP_JAL: illegal = 1'b0;
      default:   illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11)
      illegal = 1'b1;
  end
`endif

  always_comb begin
    dec          = '0;
    dec.pc       = pc;
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.rd       = instr[11:7];
    dec.alu_ctrl = ALU_ADD;
    dec.src_a    = SRC_A_RS1;
    dec.wb_sel   = WB_ALU;
    case (opcode)
      OP_R: begin
        dec.alu_ctrl = {instr[30], f3};
        dec.reg_wr   = 1'b1;
      end
      OP_I: begin
        // Only the right shifts use bit30 to pick arithmetic vs logical.
        dec.alu_ctrl = (f3 == 3'b101) ? {instr[30], f3} : {1'b0, f3};
        dec.imm      = imm_i;
        dec.src_imm  = 1'b1;
        dec.reg_wr   = 1'b1;
      end
      OP_LOAD: begin
        dec.imm      = imm_i;
        dec.src_imm  = 1'b1;
        dec.mem_rd   = 1'b1;
        dec.mem_size = f3;
        dec.wb_sel   = WB_MEM;
        dec.reg_wr   = 1'b1;
      end
      OP_STORE: begin
        dec.imm      = imm_s;
        dec.src_imm  = 1'b1;
        dec.mem_wr   = 1'b1;
        dec.mem_size = f3;
      end
      OP_BRANCH: begin
        dec.imm       = imm_b;
        dec.alu_ctrl  = ALU_SUB;
        dec.branch    = 1'b1;
        dec.br_funct3 = f3;
      end
      OP_LUI: begin
        dec.imm     = imm_u;
        dec.src_a   = SRC_A_ZERO;
        dec.src_imm = 1'b1;
        dec.reg_wr  = 1'b1;
      end
      OP_AUIPC: begin
        dec.imm     = imm_u;
        dec.src_a   = SRC_A_PC;
        dec.src_imm = 1'b1;
        dec.reg_wr  = 1'b1;
      end
      OP_JAL: begin
        dec.imm    = imm_j;
        dec.jump   = 1'b1;
        dec.wb_sel = WB_PC4;
        dec.reg_wr = 1'b1;
      end
      OP_JALR: begin
        dec.imm     = imm_i;
        dec.jalr    = 1'b1;
        dec.src_imm = 1'b1;
        dec.wb_sel  = WB_PC4;
        dec.reg_wr  = 1'b1;
      end
      default: ;
    endcase

`ifdef DECODE_ILLEGAL_CHECK_EN
    dec.illegal = illegal;
    if (illegal) begin
      dec.reg_wr = 1'b0;
      dec.mem_rd = 1'b0;
      dec.mem_wr = 1'b0;
      dec.branch = 1'b0;
      dec.jump   = 1'b0;
      dec.jalr   = 1'b0;
    end
`endif

    if (dec.rd == '0)
      dec.reg_wr = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: 1-cycle latency, one-entry output register with valid/ready,
// stall hold and flush. out_illegal exists only when DECODE_ILLEGAL_CHECK_EN is defined.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic [3:0]        out_alu_ctrl,
  output logic [1:0]        out_src_a,
  output logic              out_src_imm,
  output logic              out_branch,
  output logic              out_jump,
  output logic              out_jalr,
  output logic [2:0]        out_br_funct3,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic [2:0]        out_mem_size,
  output logic [1:0]        out_wb_sel,
  output logic              out_reg_wr
`ifdef DECODE_ILLEGAL_CHECK_EN
  ,
  output logic              out_illegal
`endif
);

  decoded_t dec;
  decoded_t q;
  logic     valid;

  decode_comb u_decode_comb (
    .instr (in_instr),
    .pc    (DEC_XLEN'(in_pc)),
    .dec   (dec)
  );

  assign in_ready = !valid || out_ready;

  // Flush wins over capture and hold; fields are left stale when not capturing.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (in_ready) begin
      valid <= in_valid;
      if (in_valid)
        q <= dec;
    end
  end

  assign out_valid     = valid;
  assign out_pc        = XLEN'(q.pc);
  assign out_rs1       = REG_AW'(q.rs1);
  assign out_rs2       = REG_AW'(q.rs2);
  assign out_rd        = REG_AW'(q.rd);
  assign out_imm       = XLEN'($signed(q.imm));
  assign out_alu_ctrl  = q.alu_ctrl;
  assign out_src_a     = q.src_a;
  assign out_src_imm   = q.src_imm;
  assign out_branch    = q.branch;
  assign out_jump      = q.jump;
  assign out_jalr      = q.jalr;
  assign out_br_funct3 = q.br_funct3;
  assign out_mem_rd    = q.mem_rd;
  assign out_mem_wr    = q.mem_wr;
  assign out_mem_size  = q.mem_size;
  assign out_wb_sel    = q.wb_sel;
  assign out_reg_wr    = q.reg_wr;
`ifdef DECODE_ILLEGAL_CHECK_EN
  assign out_illegal   = q.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  logic [3:0]  out_alu_ctrl;
  logic [1:0]  out_src_a;
  logic        out_src_imm;
  logic        out_branch, out_jump, out_jalr;
  logic [2:0]  out_br_funct3;
  logic        out_mem_rd, out_mem_wr;
  logic [2:0]  out_mem_size;
  logic [1:0]  out_wb_sel;
  logic        out_reg_wr;
`ifdef DECODE_ILLEGAL_CHECK_EN
  logic        out_illegal;
`endif

  logic [5:0]  enables;
  assign enables = {out_reg_wr, out_mem_rd, out_mem_wr, out_branch, out_jump, out_jalr};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_rd        (out_rd),
    .out_imm       (out_imm),
    .out_alu_ctrl  (out_alu_ctrl),
    .out_src_a     (out_src_a),
    .out_src_imm   (out_src_imm),
    .out_branch    (out_branch),
    .out_jump      (out_jump),
    .out_jalr      (out_jalr),
    .out_br_funct3 (out_br_funct3),
    .out_mem_rd    (out_mem_rd),
    .out_mem_wr    (out_mem_wr),
    .out_mem_size  (out_mem_size),
    .out_wb_sel    (out_wb_sel),
    .out_reg_wr    (out_reg_wr)
`ifdef DECODE_ILLEGAL_CHECK_EN
    ,
    .out_illegal   (out_illegal)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_valid",    out_valid,    0);
    check("rst_in_ready", in_ready,     1);
    check("rst_imm",      out_imm,      0);
    check("rst_rd",       out_rd,       0);
    check("rst_alu",      out_alu_ctrl, 0);
    check("rst_pc",       out_pc,       0);
    check("rst_enables",  enables,      0);
    check("rst_wb_srca",  {out_wb_sel, out_src_a, out_src_imm}, 0);

    // ADDI x1,x0,-1
    in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'hFFF00093; in_pc = 32'h100;
    tick();
    check("addi_valid",   out_valid,    1);
    check("addi_rd",      out_rd,       1);
    check("addi_imm",     out_imm,      32'hFFFFFFFF);
    check("addi_alu",     out_alu_ctrl, 4'b0000);
    check("addi_srcimm",  out_src_imm,  1);
    check("addi_regwr",   out_reg_wr,   1);
    check("addi_pc",      out_pc,       32'h100);

    // SRAI x2,x1,3
    in_instr = 32'h4030D113; in_pc = 32'h104;
    tick();
    check("srai_alu",     out_alu_ctrl, 4'b1101);
    check("srai_imm",     out_imm,      32'h00000403);
    check("srai_shamt",   out_imm[4:0], 3);
    check("srai_rs1_rd",  {out_rs1, out_rd}, {5'd1, 5'd2});

    // BEQ x1,x2,-4 then stall with SUB x3,x1,x2 waiting
    in_instr = 32'hFE208EE3; in_pc = 32'h108;
    tick();
    check("beq_branch",   out_branch,   1);
    check("beq_imm",      out_imm,      32'hFFFFFFFC);
    check("beq_alu",      out_alu_ctrl, 4'b1000);
    check("beq_regwr",    out_reg_wr,   0);
    check("beq_rs",       {out_rs1, out_rs2}, {5'd1, 5'd2});
    in_instr = 32'h402081B3; in_pc = 32'h10C;
    out_ready = 1'b0;
    #1;
    check("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid",  out_valid,    1);
      check("hold_ready",  in_ready,     0);
      check("hold_branch", out_branch,   1);
      check("hold_imm",    out_imm,      32'hFFFFFFFC);
      check("hold_alu",    out_alu_ctrl, 4'b1000);
      check("hold_pc",     out_pc,       32'h108);
    end
    out_ready = 1'b1;
    #1;
    check("release_ready", in_ready, 1);
    tick();
    check("sub_pc",       out_pc,       32'h10C);
    check("sub_alu",      out_alu_ctrl, 4'b1000);
    check("sub_rd",       out_rd,       3);
    check("sub_enables",  enables,      6'b100000);

    // LUI x5,0x12345 with coincident flush, then re-issue
    in_instr = 32'h123452B7; in_pc = 32'h110;
    flush = 1'b1;
    tick();
    check("flush_valid",  out_valid,    0);
    flush = 1'b0;
    tick();
    check("lui_valid",    out_valid,    1);
    check("lui_imm",      out_imm,      32'h12345000);
    check("lui_srca",     out_src_a,    2'b10);
    check("lui_regwr",    out_reg_wr,   1);
    check("lui_rd",       out_rd,       5);

    // JAL x0,0
    in_instr = 32'h0000006F; in_pc = 32'h114;
    tick();
    check("jal_jump",     out_jump,     1);
    check("jal_wb",       out_wb_sel,   2'b10);
    check("jal_regwr",    out_reg_wr,   0);

    // JALR x1,8(x2)
    in_instr = 32'h008100E7; in_pc = 32'h118;
    tick();
    check("jalr_jalr",    out_jalr,     1);
    check("jalr_imm",     out_imm,      8);
    check("jalr_regwr",   out_reg_wr,   1);
    check("jalr_rs1",     out_rs1,      2);
    check("jalr_wb_imm",  {out_wb_sel, out_src_imm}, 3'b101);

    // SW x2,12(x1): rd field nonzero but no register write
    in_instr = 32'h0020A623; in_pc = 32'h11C;
    tick();
    check("sw_enables",   enables,      6'b001000);
    check("sw_imm",       out_imm,      12);
    check("sw_size",      out_mem_size, 3'b010);

    // LW x4,-8(x1)
    in_instr = 32'hFF80A203; in_pc = 32'h120;
    tick();
    check("lw_enables",   enables,      6'b110000);
    check("lw_imm",       out_imm,      32'hFFFFFFF8);
    check("lw_wb",        out_wb_sel,   2'b01);

    // Drain
    in_valid = 1'b0;
    tick();
    check("drain_valid",  out_valid,    0);

    // All-zero word held under stall, then flushed out of the hold
    in_valid = 1'b1; out_ready = 1'b0;
    in_instr = 32'h00000000; in_pc = 32'h124;
    tick();
    check("zero_valid",   out_valid,    1);
    check("zero_enables", enables,      0);
`ifdef DECODE_ILLEGAL_CHECK_EN
    check("zero_illegal", out_illegal,  1);
`endif
    in_valid = 1'b0; flush = 1'b1;
    tick();
    check("hold_flush_valid", out_valid, 0);
    flush = 1'b0;
    tick();
    check("post_flush_ready", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
